// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the multiply sequencer.
//   MUL_OP      : opcode that starts a multiply
//   IDLE..DONE  : 2-bit state encoding of the multiply sequencer
//   WIDTH_DEF   : default operand width
//   OUT_W_DEF   : default result width
package alu_pkg;

  localparam logic [5:0] MUL_OP = 6'b000100;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int WIDTH_DEF = 5;
  localparam int OUT_W_DEF = 32;

endpackage

// File: rtl/mul_sequencer_popcount_serial.sv
// Bit-serial ones counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear of the running count
//   en_i       : add data_i[idx_i] to the running count this cycle
//   data_i     : vector being counted
//   idx_i      : bit index sampled this cycle
//   even_o     : 1 when the count, including the bit being added now, is even
module popcount_serial #(
  parameter int W  = 10,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [W-1:0]  data_i,
  input  logic [IW-1:0] idx_i,
  output logic          even_o
);

  logic [3:0] ones_q;
  logic       bit_w;

  assign bit_w = data_i[idx_i];

  // Parity looks ahead by one bit so the caller can capture the final
  // result on the same edge that the last bit is counted.
  assign even_o = ~(ones_q[0] ^ (en_i & bit_w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
    end else if (clr_i) begin
      ones_q <= 4'd0;
    end else if (en_i) begin
      ones_q <= ones_q + {3'd0, bit_w};
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier sequencer for the ALU multiply opcode.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, printout    : request and its opcode, sampled only in IDLE
//   Number1, Number2   : unsigned multiplicand / multiplier
//   ack                : result accepted (only while done is high)
//   busy               : operation in progress or result pending
//   done               : result valid
//   op_err             : one-cycle pulse for a start with a non-multiply opcode
//   balancebit         : 1 when the product has an even number of ones
//   conclusion         : product sign-extended to OUT_W bits
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int         WIDTH  = WIDTH_DEF,
  parameter int         OUT_W  = OUT_W_DEF,
  parameter logic [5:0] MUL_OP = alu_pkg::MUL_OP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       printout,
  input  logic [WIDTH-1:0] Number1,
  input  logic [WIDTH-1:0] Number2,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             op_err,
  output logic             balancebit,
  output logic [OUT_W-1:0] conclusion
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = $clog2(PW);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    step_q, step_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             op_err_q, op_err_d;
  logic             bal_q, bal_d;
  logic [OUT_W-1:0] concl_q, concl_d;
  logic             even_w;

  // Counter is held clear outside COUNT so every pass starts from zero.
  popcount_serial #(
    .W  (PW),
    .IW (IW)
  ) u_popcount (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q != COUNT),
    .en_i   (state_q == COUNT),
    .data_i (acc_q),
    .idx_i  (idx_q),
    .even_o (even_w)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    step_d   = step_q;
    idx_d    = idx_q;
    op_err_d = 1'b0;
    done_d   = 1'b0;
    bal_d    = bal_q;
    concl_d  = concl_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (printout == MUL_OP) begin
            a_d     = Number1;
            b_d     = Number2;
            acc_d   = '0;
            step_d  = '0;
            state_d = CALC;
          end else begin
            op_err_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (b_q[step_q]) begin
          acc_d = acc_q + (PW'(a_q) << step_q);
        end
        step_d = step_q + 1'b1;
        if (step_q == SW'(WIDTH - 1)) begin
          step_d  = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(PW - 1)) begin
          idx_d   = '0;
          state_d = DONE;
          bal_d   = even_w;
          concl_d = {{(OUT_W - PW){acc_q[PW-1]}}, acc_q};
        end
      end
      DONE: begin
        // done rises one cycle after DONE entry; ack only counts once the
        // consumer has been able to see done, and start is ignored here.
        if (ack && done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
      bal_q    <= 1'b0;
      concl_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      op_err_q <= op_err_d;
      bal_q    <= bal_d;
      concl_q  <= concl_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign op_err     = op_err_q;
  assign balancebit = bal_q;
  assign conclusion = concl_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  printout;
  logic [4:0]  Number1;
  logic [4:0]  Number2;
  logic        ack;
  logic        busy;
  logic        done;
  logic        op_err;
  logic        balancebit;
  logic [31:0] conclusion;

  mul_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .printout   (printout),
    .Number1    (Number1),
    .Number2    (Number2),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .op_err     (op_err),
    .balancebit (balancebit),
    .conclusion (conclusion)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] concl;
    logic        bal;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [4:0] a, input logic [4:0] b);
    exp_t       e;
    logic [9:0] p;
    p       = {5'd0, a} * {5'd0, b};
    e.concl = {{22{p[9]}}, p};
    e.bal   = ~(^p);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b);
    start    = 1'b1;
    printout = 6'b000100;
    Number1  = a;
    Number2  = b;
    exp_q.push_back(model(a, b));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      last_exp = e;
      check({tag, "_concl"}, conclusion, e.concl);
      check({tag, "_bal"}, {31'd0, balancebit}, {31'd0, e.bal});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  int          lat;
  logic [31:0] held_concl;
  logic        held_bal;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    printout = 6'd0;
    Number1  = 5'd0;
    Number2  = 5'd0;
    ack      = 1'b0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_operr", {31'd0, op_err}, 32'd0);
    check("rst_bal", {31'd0, balancebit}, 32'd0);
    check("rst_concl", conclusion, 32'd0);
    rst_n = 1'b1;
    step();

    // 5 x 3, with a stray ack while calculating
    issue(5'd5, 5'd3);
    check("m53_busy", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    wait_done(lat);
    check("m53_lat", 32'(lat + 1), 32'd16);
    check_result("m53");
    do_ack("m53");

    // 31 x 31, sign-extended result
    step();
    issue(5'd31, 5'd31);
    wait_done(lat);
    check("m31_lat", 32'(lat), 32'd16);
    check_result("m31");
    do_ack("m31");

    // 0 x 17 then 7 x 1 back to back
    issue(5'd0, 5'd17);
    wait_done(lat);
    check("m0_lat", 32'(lat), 32'd16);
    check_result("m0");
    do_ack("m0");
    issue(5'd7, 5'd1);
    wait_done(lat);
    check("m7_ack_to_done", 32'(lat + 1), 32'd17);
    check_result("m7");
    do_ack("m7");

    // bad opcode
    start    = 1'b1;
    printout = 6'b000011;
    Number1  = 5'd9;
    Number2  = 5'd9;
    step();
    start = 1'b0;
    check("operr_pulse", {31'd0, op_err}, 32'd1);
    check("operr_busy", {31'd0, busy}, 32'd0);
    check("operr_concl", conclusion, last_exp.concl);
    step();
    check("operr_clr", {31'd0, op_err}, 32'd0);
    check("operr_busy2", {31'd0, busy}, 32'd0);

    // reset during COUNT
    issue(5'd5, 5'd3);
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_operr", {31'd0, op_err}, 32'd0);
    check("mid_rst_bal", {31'd0, balancebit}, 32'd0);
    check("mid_rst_concl", conclusion, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    issue(5'd7, 5'd1);
    wait_done(lat);
    check("post_rst_lat", 32'(lat), 32'd16);
    check_result("post_rst");

    // hold in DONE while operands change
    held_concl = conclusion;
    held_bal   = balancebit;
    for (int i = 0; i < 10; i++) begin
      Number1  = 5'($urandom_range(0, 31));
      Number2  = 5'($urandom_range(0, 31));
      printout = 6'b000100;
      step();
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_concl", conclusion, held_concl);
      check("hold_bal", {31'd0, balancebit}, {31'd0, held_bal});
    end

    // start and ack together: leave DONE, no new operation
    start = 1'b1;
    ack   = 1'b1;
    step();
    start = 1'b0;
    ack   = 1'b0;
    check("sa_done", {31'd0, done}, 32'd0);
    check("sa_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    check("sa_busy_later", {31'd0, busy}, 32'd0);
    check("sa_concl_kept", conclusion, held_concl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
